// File: rtl/uart_fifo_ctrl_pkg.sv
// Shared types and constants for the uart FIFO sequencer.
// TX state encodings, WAIT_BUSY timeout and common widths.
package uart_fifo_ctrl_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned TX_TIMEOUT = 4;
  localparam int unsigned TX_TIMER_W = $clog2(TX_TIMEOUT);

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_LOAD      = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_ctrl_if.sv
// Host-bus and uart-side signal bundle for uart_fifo_ctrl.
// slave is the controller view; master is the host/uart environment view.
interface uart_fifo_ctrl_if
  import uart_fifo_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned ERR_W   = 8
);

  logic                tx_wr_en;
  logic [BYTE_W-1:0]   tx_wr_data;
  logic                tx_full;
  logic [FIFO_AW:0]    tx_count;
  logic                rx_rd_en;
  logic [BYTE_W-1:0]   rx_rd_data;
  logic                rx_empty;
  logic [FIFO_AW:0]    rx_count;
  logic                rx_overflow;
  logic [ERR_W-1:0]    rx_err_count;
  logic                clear_status;
  logic                uart_transmit;
  logic [BYTE_W-1:0]   uart_tx_byte;
  logic                uart_is_transmitting;
  logic                uart_received;
  logic [BYTE_W-1:0]   uart_rx_byte;
  logic                uart_rx_error;
  logic                busy;

  modport slave (
    input  tx_wr_en, tx_wr_data, rx_rd_en, clear_status,
    input  uart_is_transmitting, uart_received, uart_rx_byte, uart_rx_error,
    output tx_full, tx_count, rx_rd_data, rx_empty, rx_count,
    output rx_overflow, rx_err_count, uart_transmit, uart_tx_byte, busy
  );

  modport master (
    output tx_wr_en, tx_wr_data, rx_rd_en, clear_status,
    output uart_is_transmitting, uart_received, uart_rx_byte, uart_rx_error,
    input  tx_full, tx_count, rx_rd_data, rx_empty, rx_count,
    input  rx_overflow, rx_err_count, uart_transmit, uart_tx_byte, busy
  );

endinterface

// File: rtl/uart_fifo_ctrl_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned      DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_wr_c;
  logic              do_rd_c;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_rd_c = rd_en && !empty;
  assign do_wr_c = wr_en && (!full || do_rd_c);
  assign rd_data = mem[rd_ptr];

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr_c) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd_c) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr_c, do_rd_c})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are never visible past the count
  always_ff @(posedge clk) begin
    if (do_wr_c) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Host-side sequencer for the uart core: TX FIFO feeding the transmit
// handshake, RX capture FIFO, sticky overflow and saturating error count.
module uart_fifo_ctrl
  import uart_fifo_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned ERR_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  uart_fifo_ctrl_if.slave bus
);

  localparam logic [ERR_W-1:0]      ERR_MAX  = '1;
  localparam logic [TX_TIMER_W-1:0] TMO_LAST = TX_TIMER_W'(TX_TIMEOUT - 1);

  tx_state_e               state_q;
  tx_state_e               state_d;
  logic [TX_TIMER_W-1:0]   timer_q;
  logic [TX_TIMER_W-1:0]   timer_d;
  logic [BYTE_W-1:0]       tx_byte_d;
  logic [BYTE_W-1:0]       tx_head;
  logic                    tx_empty;
  logic                    tx_rd_en_c;
  logic                    rx_full;
  logic                    err_prev_q;
  logic                    err_rise_c;
  logic                    ovf_set_c;

  sync_fifo #(.DATA_W(BYTE_W), .ADDR_W(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.tx_wr_en),
    .wr_data (bus.tx_wr_data),
    .rd_en   (tx_rd_en_c),
    .rd_data (tx_head),
    .full    (bus.tx_full),
    .empty   (tx_empty),
    .count   (bus.tx_count)
  );

  sync_fifo #(.DATA_W(BYTE_W), .ADDR_W(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.uart_received),
    .wr_data (bus.uart_rx_byte),
    .rd_en   (bus.rx_rd_en),
    .rd_data (bus.rx_rd_data),
    .full    (rx_full),
    .empty   (bus.rx_empty),
    .count   (bus.rx_count)
  );

  assign bus.busy = (state_q != TX_IDLE) || !tx_empty;

  // TX sequencer next-state; a byte is popped only on the IDLE->LOAD hop
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    tx_byte_d  = bus.uart_tx_byte;
    tx_rd_en_c = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (!tx_empty && !bus.uart_is_transmitting) begin
          tx_rd_en_c = 1'b1;
          tx_byte_d  = tx_head;
          state_d    = TX_LOAD;
        end
      end
      TX_LOAD: begin
        timer_d = '0;
        state_d = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: begin
        if (bus.uart_is_transmitting) state_d = TX_WAIT_DONE;
        else if (timer_q == TMO_LAST) state_d = TX_IDLE;
        else                          timer_d = timer_q + 1'b1;
      end
      TX_WAIT_DONE: begin
        if (!bus.uart_is_transmitting) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // uart_transmit is high exactly while the registered state is LOAD
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q           <= TX_IDLE;
      timer_q           <= '0;
      bus.uart_tx_byte  <= '0;
      bus.uart_transmit <= 1'b0;
    end else begin
      state_q           <= state_d;
      timer_q           <= timer_d;
      bus.uart_tx_byte  <= tx_byte_d;
      bus.uart_transmit <= (state_d == TX_LOAD);
    end
  end

  assign err_rise_c = bus.uart_rx_error && !err_prev_q;
  assign ovf_set_c  = bus.uart_received && rx_full && !bus.rx_rd_en;

  // Status; clear wins over a same-cycle increment or overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_prev_q       <= 1'b0;
      bus.rx_overflow  <= 1'b0;
      bus.rx_err_count <= '0;
    end else begin
      err_prev_q <= bus.uart_rx_error;
      if (bus.clear_status) begin
        bus.rx_overflow  <= 1'b0;
        bus.rx_err_count <= '0;
      end else begin
        if (ovf_set_c) bus.rx_overflow <= 1'b1;
        if (err_rise_c && (bus.rx_err_count != ERR_MAX))
          bus.rx_err_count <= bus.rx_err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed self-checking bench for uart_fifo_ctrl with a small looped uart model.
module tb_uart_fifo_ctrl;
  import uart_fifo_ctrl_pkg::*;

  localparam int unsigned FRAME = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       loop_en;
  logic       m_busy, m_rcv;
  logic [7:0] m_byte, m_lat;
  logic       t_busy, t_rcv, t_err, t_err2;
  logic [7:0] t_byte;
  int         checks = 0;
  int         errors = 0;

  uart_fifo_ctrl_if #(.FIFO_AW(4), .ERR_W(8)) bus ();
  uart_fifo_ctrl_if #(.FIFO_AW(4), .ERR_W(2)) bus2 ();

  uart_fifo_ctrl #(.FIFO_AW(4), .ERR_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
  uart_fifo_ctrl #(.FIFO_AW(4), .ERR_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus.uart_is_transmitting = loop_en ? m_busy : t_busy;
  assign bus.uart_received        = loop_en ? m_rcv  : t_rcv;
  assign bus.uart_rx_byte         = loop_en ? m_byte : t_byte;
  assign bus.uart_rx_error        = t_err;

  assign bus2.tx_wr_en             = 1'b0;
  assign bus2.tx_wr_data           = 8'h00;
  assign bus2.rx_rd_en             = 1'b0;
  assign bus2.clear_status         = 1'b0;
  assign bus2.uart_is_transmitting = 1'b0;
  assign bus2.uart_received        = 1'b0;
  assign bus2.uart_rx_byte         = 8'h00;
  assign bus2.uart_rx_error        = t_err2;

  // uart stand-in: busy for FRAME cycles after a transmit, then loops the byte to rx
  initial begin
    m_busy = 1'b0; m_rcv = 1'b0; m_byte = 8'h00; m_lat = 8'h00;
    forever begin
      @(posedge clk); #2;
      if (loop_en && bus.uart_transmit) begin
        m_lat  = bus.uart_tx_byte;
        m_busy = 1'b1;
        repeat (FRAME) @(posedge clk);
        #2 m_busy = 1'b0; m_rcv = 1'b1; m_byte = m_lat;
        @(posedge clk);
        #2 m_rcv = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; tick(); rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; tick(); tick(); rst = 1'b1; tick();
    checks++; if (bus.tx_count !== 5'd0) begin errors++; $display("FAIL por_tx_count: got %0d want 0", bus.tx_count); end
    checks++; if (bus.rx_empty !== 1'b1) begin errors++; $display("FAIL por_rx_empty: got %b want 1", bus.rx_empty); end
    checks++; if (bus.uart_tx_byte !== 8'h00) begin errors++; $display("FAIL por_tx_byte: got %0h want 0", bus.uart_tx_byte); end
    t_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin bus.tx_wr_en = 1'b1; bus.tx_wr_data = 8'(8'h10 + i); tick(); end
    bus.tx_wr_en = 1'b0;
    checks++; if (bus.tx_count !== 5'd3) begin errors++; $display("FAIL pre_rst_tx_count: got %0d want 3", bus.tx_count); end
    do_reset(); tick();
    checks++; if (bus.tx_count !== 5'd0 || bus.tx_full !== 1'b0) begin errors++; $display("FAIL rst_tx_fifo: count %0d full %b want 0 0", bus.tx_count, bus.tx_full); end
    checks++; if (bus.rx_empty !== 1'b1 || bus.rx_count !== 5'd0) begin errors++; $display("FAIL rst_rx_fifo: empty %b count %0d want 1 0", bus.rx_empty, bus.rx_count); end
    checks++; if (bus.uart_transmit !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_idle: transmit %b busy %b want 0 0", bus.uart_transmit, bus.busy); end
    checks++; if (bus.rx_overflow !== 1'b0 || bus.rx_err_count !== 8'd0) begin errors++; $display("FAIL rst_status: ovf %b errcnt %0d want 0 0", bus.rx_overflow, bus.rx_err_count); end
    t_busy = 1'b0;
  endtask

  task automatic test_tx_order();
    logic [7:0] exp_b [3];
    int pulses, highs;
    logic prev;
    exp_b = '{8'h55, 8'hA3, 8'h0F};
    pulses = 0; highs = 0; prev = 1'b0;
    do_reset(); loop_en = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (cyc < 3) begin bus.tx_wr_en = 1'b1; bus.tx_wr_data = exp_b[cyc]; end
      else bus.tx_wr_en = 1'b0;
      tick();
      if (bus.uart_transmit) begin
        highs++;
        if (!prev) begin
          if (pulses < 3) begin
            checks++; if (bus.uart_tx_byte !== exp_b[pulses]) begin errors++; $display("FAIL order_byte%0d: got %0h want %0h", pulses, bus.uart_tx_byte, exp_b[pulses]); end
          end
          checks++; if (bus.uart_is_transmitting !== 1'b0) begin errors++; $display("FAIL order_pulse_while_busy: is_transmitting %b want 0", bus.uart_is_transmitting); end
          pulses++;
        end
      end
      prev = bus.uart_transmit;
    end
    checks++; if (pulses !== 3 || highs !== 3) begin errors++; $display("FAIL order_pulses: pulses %0d high_cycles %0d want 3 3", pulses, highs); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL order_busy_end: got %b want 0", bus.busy); end
    checks++; if (bus.rx_count !== 5'd3) begin errors++; $display("FAIL loop_rx_count: got %0d want 3", bus.rx_count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.rx_rd_data !== exp_b[i]) begin errors++; $display("FAIL loop_rx_byte%0d: got %0h want %0h", i, bus.rx_rd_data, exp_b[i]); end
      bus.rx_rd_en = 1'b1; tick(); bus.rx_rd_en = 1'b0;
    end
    checks++; if (bus.rx_empty !== 1'b1) begin errors++; $display("FAIL loop_rx_drained: empty %b want 1", bus.rx_empty); end
    loop_en = 1'b0;
  endtask

  task automatic test_tx_full();
    do_reset(); t_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.tx_wr_en = 1'b1; bus.tx_wr_data = 8'(i); tick();
      if (i == 14) begin
        checks++; if (bus.tx_full !== 1'b0) begin errors++; $display("FAIL full_early: got %b want 0 at 15 entries", bus.tx_full); end
      end
      if (i == 15) begin
        checks++; if (bus.tx_full !== 1'b1 || bus.tx_count !== 5'd16) begin errors++; $display("FAIL full_at16: full %b count %0d want 1 16", bus.tx_full, bus.tx_count); end
      end
    end
    bus.tx_wr_en = 1'b0;
    checks++; if (bus.tx_count !== 5'd16 || bus.tx_full !== 1'b1) begin errors++; $display("FAIL full_17th_ignored: count %0d full %b want 16 1", bus.tx_count, bus.tx_full); end
    t_busy = 1'b0; bus.tx_wr_en = 1'b1; bus.tx_wr_data = 8'hAA; tick();
    bus.tx_wr_en = 1'b0; t_busy = 1'b1;
    checks++; if (bus.tx_count !== 5'd16) begin errors++; $display("FAIL full_push_pop: count %0d want 16", bus.tx_count); end
    checks++; if (bus.uart_transmit !== 1'b1 || bus.uart_tx_byte !== 8'h00) begin errors++; $display("FAIL full_pop_head: transmit %b byte %0h want 1 00", bus.uart_transmit, bus.uart_tx_byte); end
    t_busy = 1'b0; do_reset();
  endtask

  task automatic test_rx_overflow();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      t_rcv = 1'b1; t_byte = 8'(i); tick(); t_rcv = 1'b0; tick();
      if (i == 15) begin
        checks++; if (bus.rx_overflow !== 1'b0 || bus.rx_count !== 5'd16) begin errors++; $display("FAIL rx_fill16: ovf %b count %0d want 0 16", bus.rx_overflow, bus.rx_count); end
      end
    end
    checks++; if (bus.rx_overflow !== 1'b1 || bus.rx_count !== 5'd16) begin errors++; $display("FAIL rx_overflow: ovf %b count %0d want 1 16", bus.rx_overflow, bus.rx_count); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.rx_rd_data !== 8'(i)) begin errors++; $display("FAIL rx_read%0d: got %0h want %0h", i, bus.rx_rd_data, 8'(i)); end
      bus.rx_rd_en = 1'b1; tick(); bus.rx_rd_en = 1'b0;
    end
    checks++; if (bus.rx_empty !== 1'b1 || bus.rx_overflow !== 1'b1) begin errors++; $display("FAIL rx_drained: empty %b ovf %b want 1 1", bus.rx_empty, bus.rx_overflow); end
    bus.clear_status = 1'b1; tick(); bus.clear_status = 1'b0;
    checks++; if (bus.rx_overflow !== 1'b0) begin errors++; $display("FAIL rx_clear: ovf %b want 0", bus.rx_overflow); end
    bus.rx_rd_en = 1'b1; tick(); bus.rx_rd_en = 1'b0;
    checks++; if (bus.rx_count !== 5'd0) begin errors++; $display("FAIL rx_read_empty: count %0d want 0", bus.rx_count); end
    t_rcv = 1'b1; t_byte = 8'h5A; bus.rx_rd_en = 1'b1; tick(); t_rcv = 1'b0; bus.rx_rd_en = 1'b0;
    checks++; if (bus.rx_count !== 5'd1 || bus.rx_rd_data !== 8'h5A) begin errors++; $display("FAIL rx_push_empty_rd: count %0d data %0h want 1 5a", bus.rx_count, bus.rx_rd_data); end
    for (int i = 0; i < 15; i++) begin t_rcv = 1'b1; t_byte = 8'(8'h60 + i); tick(); end
    t_byte = 8'hEE; bus.rx_rd_en = 1'b1; tick(); t_rcv = 1'b0; bus.rx_rd_en = 1'b0;
    checks++; if (bus.rx_count !== 5'd16 || bus.rx_overflow !== 1'b0 || bus.rx_rd_data !== 8'h60) begin errors++; $display("FAIL rx_full_rd_push: count %0d ovf %b head %0h want 16 0 60", bus.rx_count, bus.rx_overflow, bus.rx_rd_data); end
    do_reset();
  endtask

  task automatic test_err_count();
    do_reset(); t_err = 1'b0;
    t_err = 1'b1; tick(); t_err = 1'b0; tick();
    t_err = 1'b1; repeat (5) tick(); t_err = 1'b0; tick();
    t_err = 1'b1; tick(); t_err = 1'b0; tick();
    checks++; if (bus.rx_err_count !== 8'd3) begin errors++; $display("FAIL err_count3: got %0d want 3", bus.rx_err_count); end
    t_err = 1'b1; bus.clear_status = 1'b1; tick(); bus.clear_status = 1'b0;
    checks++; if (bus.rx_err_count !== 8'd0) begin errors++; $display("FAIL err_clear_priority: got %0d want 0", bus.rx_err_count); end
    tick();
    checks++; if (bus.rx_err_count !== 8'd0) begin errors++; $display("FAIL err_level_no_edge: got %0d want 0", bus.rx_err_count); end
    t_err = 1'b0; tick();
  endtask

  task automatic test_err_saturate();
    do_reset(); t_err2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      t_err2 = 1'b1; tick(); t_err2 = 1'b0; tick();
      if (i == 3) begin
        checks++; if (bus2.rx_err_count !== 2'd3) begin errors++; $display("FAIL sat_edge4: got %0d want 3", bus2.rx_err_count); end
      end
    end
    checks++; if (bus2.rx_err_count !== 2'd3) begin errors++; $display("FAIL sat_edge5: got %0d want 3", bus2.rx_err_count); end
  endtask

  task automatic test_timeout();
    int pulses, first_cyc, second_cyc;
    logic [7:0] b0, b1;
    pulses = 0; first_cyc = -1; second_cyc = -1; b0 = 8'h00; b1 = 8'h00;
    do_reset(); t_busy = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc < 2) begin bus.tx_wr_en = 1'b1; bus.tx_wr_data = (cyc == 0) ? 8'hC1 : 8'hC2; end
      else bus.tx_wr_en = 1'b0;
      tick();
      if (bus.uart_transmit) begin
        if (pulses == 0) begin first_cyc = cyc; b0 = bus.uart_tx_byte; end
        if (pulses == 1) begin second_cyc = cyc; b1 = bus.uart_tx_byte; end
        pulses++;
      end
    end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL tmo_pulses: got %0d want 2", pulses); end
    checks++; if (b0 !== 8'hC1 || b1 !== 8'hC2) begin errors++; $display("FAIL tmo_bytes: got %0h %0h want c1 c2", b0, b1); end
    checks++; if (second_cyc - first_cyc !== 6) begin errors++; $display("FAIL tmo_spacing: got %0d cycles want 6", second_cyc - first_cyc); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_idle_end: busy %b want 0", bus.busy); end
  endtask

  initial begin
    rst = 1'b0; loop_en = 1'b0;
    t_busy = 1'b0; t_rcv = 1'b0; t_byte = 8'h00; t_err = 1'b0; t_err2 = 1'b0;
    bus.tx_wr_en = 1'b0; bus.tx_wr_data = 8'h00; bus.rx_rd_en = 1'b0; bus.clear_status = 1'b0;
    test_reset();
    test_tx_order();
    test_tx_full();
    test_rx_overflow();
    test_err_count();
    test_err_saturate();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
Sequencer that sits between a host bus and the generic uart core. It buffers outbound bytes in a TX FIFO and hands them to the uart one at a time using the uart's transmit/is_transmitting handshake. It also captures every received byte into an RX FIFO and keeps status: a sticky overflow flag and a saturating RX error count.

Parameters:
FIFO_AW, 4, log2 FIFO depth; each FIFO holds 2**FIFO_AW entries (default 16).
ERR_W, 8, width of the saturating rx error counter.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low (asserted when 0)
tx_wr_en  in  1  push tx_wr_data into TX FIFO
tx_wr_data  in  8  byte to transmit
tx_full  out  1  TX FIFO full
tx_count  out  FIFO_AW+1  TX FIFO occupancy
rx_rd_en  in  1  pop RX FIFO head
rx_rd_data  out  8  RX FIFO head (first-word fall-through)
rx_empty  out  1  RX FIFO empty
rx_count  out  FIFO_AW+1  RX FIFO occupancy
rx_overflow  out  1  sticky: received byte dropped because RX FIFO was full
rx_err_count  out  ERR_W  saturating count of uart rx_error rising edges
clear_status  in  1  clears rx_overflow and rx_err_count
uart_transmit  out  1  to uart transmit (one-cycle pulse)
uart_tx_byte  out  8  to uart tx_byte
uart_is_transmitting  in  1  from uart
uart_received  in  1  from uart (one-cycle pulse)
uart_rx_byte  in  8  from uart
uart_rx_error  in  1  from uart (level)
busy  out  1  TX sequencer not in IDLE, or TX FIFO not empty

Behaviour:
- Reset (rst==0 at a clk edge):
  - Both FIFOs emptied: tx_full=0, rx_empty=1, counts=0.
  - uart_transmit=0, uart_tx_byte=0, rx_overflow=0, rx_err_count=0.
  - TX state=IDLE; previous-rx_error register cleared to 0.
  - Reset mid-byte discards all FIFO contents. The uart is not reset by this block.
- TX sequencer states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
  - IDLE: if TX FIFO not empty and uart_is_transmitting==0, pop the head into uart_tx_byte, go to LOAD.
  - LOAD: uart_transmit=1 for exactly this cycle; uart_tx_byte held stable; go to WAIT_BUSY.
  - WAIT_BUSY: wait for uart_is_transmitting==1, then go to WAIT_DONE. If it is not seen within 4 cycles, return to IDLE (byte lost, no retry).
  - WAIT_DONE: when uart_is_transmitting==0, go to IDLE.
  - Minimum gap between transmit pulses is therefore one full uart frame plus 2 cycles.
  - uart_transmit is never asserted outside LOAD.
- TX FIFO:
  - Push when tx_wr_en and !tx_full; a push while full is silently ignored.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- RX capture:
  - On uart_received==1, write uart_rx_byte into the RX FIFO.
  - If the RX FIFO is full and rx_rd_en is not asserted that cycle, the byte is dropped and rx_overflow is set (sticky).
  - If full and rx_rd_en is asserted the same cycle, the pop and the push both occur; no overflow.
- RX read:
  - rx_rd_data always shows the head entry; it is undefined while rx_empty=1.
  - rx_rd_en while empty is ignored.
  - A simultaneous push into an empty FIFO with rx_rd_en: the pop is ignored and the new byte becomes visible the next cycle.
- Error count:
  - rx_err_count increments on each 0->1 edge of uart_rx_error and saturates at 2**ERR_W-1.
  - clear_status zeroes rx_err_count and rx_overflow. Clear has priority over a same-cycle increment or overflow set.
- FIFO pointers: FIFO_AW-bit, wrap naturally; occupancy counts are FIFO_AW+1 bits.
- All outputs are registered except tx_full, rx_empty, busy and rx_rd_data (decoded or read combinationally from FIFO state).

Decomposition:
- Shared package: TX state encodings (IDLE=0, LOAD=1, WAIT_BUSY=2, WAIT_DONE=3) and the WAIT_BUSY timeout constant (4).
- One natural sub-module, sync_fifo (params DATA_W, ADDR_W; ports clk, rst, wr_en, wr_data, rd_en, rd_data, full, empty, count), instantiated twice.
- sync_fifo uses the same synchronous active-low rst.

Test Plan:
- Reset: push 3 bytes, assert rst low for 1 cycle -> tx_count=0, rx_empty=1, uart_transmit=0, state IDLE.
- TX order: push 0x55,0xA3,0x0F back-to-back with the uart model looped to rx -> exactly 3 single-cycle uart_transmit pulses, bytes in order, each pulse only after is_transmitting falls; busy=0 at end.
- TX full: push 17 bytes with the uart held busy -> tx_full=1 after 16, 17th ignored, tx_count=16; with a simultaneous pop, the push is accepted.
- RX overflow: inject 17 uart_received pulses (0x00..0x10) without reads -> rx_count=16, rx_overflow=1, reads return 0x00..0x0F; clear_status -> rx_overflow=0.
- Error count: pulse uart_rx_error 3 times, with one 5-cycle-long assertion -> rx_err_count=3; with ERR_W=2, 5 edges -> saturates at 3; clear_status in the same cycle as an edge -> 0.
- Timeout: uart_is_transmitting stuck at 0 after LOAD -> return to IDLE after 4 cycles, next byte issued.
